// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard and forwarding controller: tracks in-flight destinations
// over DEPTH post-ID stages, forwards from the youngest producer and raises load-use stalls.
module pipe_hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [RA_W-1:0]       id_rs1,
    input  logic [RA_W-1:0]       id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [RA_W-1:0]       id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic                  mem_wait,
    input  logic [XLEN-1:0]       rf_data1,
    input  logic [XLEN-1:0]       rf_data2,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic [XLEN-1:0]       fwd_data1,
    output logic [XLEN-1:0]       fwd_data2,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic                  stall,
    output logic                  freeze,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [DEPTH:1]           e_v;
    logic [DEPTH:1]           e_ld;
    logic [DEPTH:1][RA_W-1:0] e_rd;
    logic                     ld_hz1;
    logic                     ld_hz2;

    // Scan oldest to youngest so the smallest matching stage is the one that sticks.
    always_comb begin
        ld_hz1    = 1'b0;
        ld_hz2    = 1'b0;
        fwd_sel1  = '0;
        fwd_sel2  = '0;
        fwd_data1 = rf_data1;
        fwd_data2 = rf_data2;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_rs1_used && id_rs1 != '0 && e_v[k] && e_rd[k] == id_rs1) begin
                fwd_sel1  = SEL_W'(k);
                fwd_data1 = stage_data[(k-1)*XLEN +: XLEN];
                ld_hz1    = e_ld[k] && (k < LOAD_STAGE);
            end
            if (id_rs2_used && id_rs2 != '0 && e_v[k] && e_rd[k] == id_rs2) begin
                fwd_sel2  = SEL_W'(k);
                fwd_data2 = stage_data[(k-1)*XLEN +: XLEN];
                ld_hz2    = e_ld[k] && (k < LOAD_STAGE);
            end
        end
    end

    assign stall  = id_valid & (ld_hz1 | ld_hz2) & ~flush & ~mem_wait;
    assign freeze = mem_wait;

    // Memory wait freezes everything, including counters; flush is ignored until it drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_v       <= '0;
            e_ld      <= '0;
            e_rd      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_wait) begin
            for (int k = DEPTH; k >= 2; k--) begin
                e_v[k]  <= e_v[k-1];
                e_ld[k] <= e_ld[k-1];
                e_rd[k] <= e_rd[k-1];
            end
            if (flush || stall) begin
                e_v[1] <= 1'b0;
            end else begin
                e_v[1] <= id_valid & id_reg_write & (id_rd != '0);
            end
            e_rd[1] <= id_rd;
            e_ld[1] <= id_is_load;
            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (defaults, CNT_W=4 for saturation).
module tb_pipe_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  id_valid;
    logic [RA_W-1:0]       id_rs1;
    logic [RA_W-1:0]       id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [RA_W-1:0]       id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  flush;
    logic                  mem_wait;
    logic [XLEN-1:0]       rf_data1;
    logic [XLEN-1:0]       rf_data2;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic [XLEN-1:0]       fwd_data1;
    logic [XLEN-1:0]       fwd_data2;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
    logic                  stall;
    logic                  freeze;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    int tests  = 0;
    int failed = 0;

    pipe_hazard_ctrl #(
        .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_STAGE(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .mem_wait(mem_wait), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .stage_data(stage_data), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall(stall), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = rw; id_is_load = ld;
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 0; mem_wait = 0;
        rf_data1 = 32'hAAAA_0001; rf_data2 = 32'hBBBB_0002;
        stage_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        set_id(1, 5, 1, 6, 1, 0, 0, 0);
        step(); step();
        tests++;
        if (stall !== 1'b0 || freeze !== 1'b0 || fwd_sel1 !== 0 || fwd_sel2 !== 0) begin
            failed++;
            $display("[TB] FAIL reset_ctrl: stall=%b freeze=%b sel1=%0d sel2=%0d, want 0 0 0 0", stall, freeze, fwd_sel1, fwd_sel2);
        end
        tests++;
        if (fwd_data1 !== rf_data1 || fwd_data2 !== rf_data2 || stall_cnt !== 0 || flush_cnt !== 0) begin
            failed++;
            $display("[TB] FAIL reset_data: d1=%h d2=%h sc=%0d fc=%0d, want aaaa0001 bbbb0002 0 0", fwd_data1, fwd_data2, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        drain();
    endtask

    task automatic test_alu_forward();
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        step();
        rf_data1 = 32'hDEAD_BEEF;
        stage_data = {32'h0, 32'h0, 32'h0000_1234};
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        tests++;
        if (fwd_sel1 !== 1 || fwd_data1 !== 32'h0000_1234 || stall !== 1'b0) begin
            failed++;
            $display("[TB] FAIL alu_fwd: sel1=%0d d1=%h stall=%b, want 1 00001234 0", fwd_sel1, fwd_data1, stall);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        step();
        rf_data2 = 32'h0BAD_0BAD;
        stage_data = {32'h0, 32'hCAFE_0001, 32'h5555_5555};
        set_id(1, 0, 0, 7, 1, 0, 0, 0);
        tests++;
        if (stall !== 1'b1) begin
            failed++;
            $display("[TB] FAIL load_use_stall: stall=%b, want 1", stall);
        end
        step();
        tests++;
        if (stall !== 1'b0 || fwd_sel2 !== 2 || fwd_data2 !== 32'hCAFE_0001 || stall_cnt !== 1) begin
            failed++;
            $display("[TB] FAIL load_use_fwd: stall=%b sel2=%0d d2=%h sc=%0d, want 0 2 cafe0001 1", stall, fwd_sel2, fwd_data2, stall_cnt);
        end
        drain();
    endtask

    task automatic test_priority();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        step(); step();
        rf_data1 = 32'hF00D_F00D; rf_data2 = 32'h0000_BEEF;
        stage_data = {32'h33, 32'h22, 32'h11};
        set_id(1, 3, 1, 0, 1, 0, 0, 0);
        tests++;
        if (fwd_sel1 !== 1 || fwd_data1 !== 32'h11) begin
            failed++;
            $display("[TB] FAIL youngest: sel1=%0d d1=%h, want 1 00000011", fwd_sel1, fwd_data1);
        end
        tests++;
        if (fwd_sel2 !== 0 || fwd_data2 !== 32'h0000_BEEF) begin
            failed++;
            $display("[TB] FAIL rs_zero: sel2=%0d d2=%h, want 0 0000beef", fwd_sel2, fwd_data2);
        end
        step();
        set_id(1, 3, 1, 0, 0, 0, 0, 0);
        tests++;
        if (fwd_sel1 !== 2 || fwd_data1 !== 32'h22) begin
            failed++;
            $display("[TB] FAIL older_prod: sel1=%0d d1=%h, want 2 00000022", fwd_sel1, fwd_data1);
        end
        drain();
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        step();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        tests++;
        if (fwd_sel1 !== 0 || fwd_data1 !== 32'hF00D_F00D || stall !== 1'b0) begin
            failed++;
            $display("[TB] FAIL rd_zero: sel1=%0d d1=%h stall=%b, want 0 f00df00d 0", fwd_sel1, fwd_data1, stall);
        end
        drain();
    endtask

    task automatic test_flush_over_stall();
        set_id(1, 0, 0, 0, 0, 9, 1, 1);
        step();
        set_id(1, 9, 1, 0, 0, 10, 1, 0);
        flush = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("[TB] FAIL flush_stall: stall=%b, want 0", stall);
        end
        step();
        flush = 1'b0;
        set_id(1, 9, 1, 10, 1, 0, 0, 0);
        tests++;
        if (flush_cnt !== 1 || stall_cnt !== 1) begin
            failed++;
            $display("[TB] FAIL flush_cnt: fc=%0d sc=%0d, want 1 1", flush_cnt, stall_cnt);
        end
        tests++;
        if (fwd_sel2 !== 0 || fwd_sel1 !== 2 || stall !== 1'b0) begin
            failed++;
            $display("[TB] FAIL flush_bubble: sel2=%0d sel1=%0d stall=%b, want 0 2 0", fwd_sel2, fwd_sel1, stall);
        end
        drain();
    endtask

    task automatic test_mem_wait();
        set_id(1, 0, 0, 0, 0, 12, 1, 1);
        step();
        set_id(1, 12, 1, 0, 0, 13, 1, 0);
        mem_wait = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (freeze !== 1'b1 || stall !== 1'b0 || fwd_sel1 !== 1 || stall_cnt !== 1 || flush_cnt !== 1) begin
                failed++;
                $display("[TB] FAIL mem_wait_%0d: freeze=%b stall=%b sel1=%0d sc=%0d fc=%0d, want 1 0 1 1 1", i, freeze, stall, fwd_sel1, stall_cnt, flush_cnt);
            end
            step();
        end
        mem_wait = 1'b0;
        #1;
        tests++;
        if (freeze !== 1'b0 || stall !== 1'b1) begin
            failed++;
            $display("[TB] FAIL wait_release: freeze=%b stall=%b, want 0 1", freeze, stall);
        end
        step();
        tests++;
        if (stall !== 1'b0 || fwd_sel1 !== 2 || stall_cnt !== 2) begin
            failed++;
            $display("[TB] FAIL wait_resume: stall=%b sel1=%0d sc=%0d, want 0 2 2", stall, fwd_sel1, stall_cnt);
        end
        drain();
    endtask

    task automatic test_reset_and_saturation();
        set_id(1, 0, 0, 0, 0, 14, 1, 1);
        step();
        set_id(1, 14, 1, 14, 1, 0, 0, 0);
        tests++;
        if (stall !== 1'b1) begin
            failed++;
            $display("[TB] FAIL pre_reset_stall: stall=%b, want 1", stall);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0 || fwd_sel1 !== 0 || fwd_sel2 !== 0 || stall_cnt !== 0 || flush_cnt !== 0) begin
            failed++;
            $display("[TB] FAIL async_reset: stall=%b sel1=%0d sel2=%0d sc=%0d fc=%0d, want 0 0 0 0 0", stall, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt);
        end
        #1 rst = 1'b0;
        step();
        tests++;
        if (stall !== 1'b0 || fwd_sel1 !== 0) begin
            failed++;
            $display("[TB] FAIL post_reset: stall=%b sel1=%0d, want 0 0", stall, fwd_sel1);
        end
        drain();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 0, 0, 0, 0, 1, 1, 1);
            step();
            set_id(1, 1, 1, 0, 0, 0, 0, 0);
            tests++;
            if (stall !== 1'b1) begin
                failed++;
                $display("[TB] FAIL sat_stall_%0d: stall=%b, want 1", i, stall);
            end
            step();
            if (i == 14) begin
                tests++;
                if (stall_cnt !== 15) begin
                    failed++;
                    $display("[TB] FAIL sat_reach: sc=%0d, want 15", stall_cnt);
                end
            end
        end
        tests++;
        if (stall_cnt !== 15) begin
            failed++;
            $display("[TB] FAIL sat_hold: sc=%0d, want 15", stall_cnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_priority();
        test_flush_over_stall();
        test_mem_wait();
        test_reset_and_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It replaces the pairwise ID-vs-EX and ID-vs-MEM hazard checks with a scoreboard of in-flight destination registers that spans DEPTH post-ID stages. Each cycle it selects the youngest valid producer for rs1 and rs2, drives the forwarded operands into ID/EX, and raises a load-use stall. It also freezes on memory wait states and kills the EX-bound instruction on a taken branch.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width (32 architectural registers; x0 is hardwired zero)
DEPTH, 3, post-ID stages tracked (1=EX, 2=MEM, 3=WB); legal range 2..6
LOAD_STAGE, 2, first stage index whose stage_data is valid for a load; legal range 1..DEPTH
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
id_valid  in  1  the ID slot holds a real instruction
id_rs1, id_rs2  in  RA_W each  source register addresses
id_rs1_used, id_rs2_used  in  1 each  the instruction reads that source
id_rd  in  RA_W  destination register address
id_reg_write  in  1  the instruction writes rd
id_is_load  in  1  the instruction is a load
flush  in  1  taken branch/jump resolved in EX
mem_wait  in  1  data or instruction memory has not acknowledged (ACKD_n or ACKI_n high)
rf_data1, rf_data2  in  XLEN each  register-file read data
stage_data  in  DEPTH*XLEN  result of stage k on bits [k*XLEN-1:(k-1)*XLEN]
fwd_data1, fwd_data2  out  XLEN each  resolved operands, to be captured into ID/EX
fwd_sel1, fwd_sel2  out  $clog2(DEPTH+1) each  0 = register file, k = stage k
stall  out  1  hold PC and IF/ID, insert a bubble into EX
freeze  out  1  hold every pipeline register
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Scoreboard state: entries e[1..DEPTH], each holding {v, rd, ld}. e[k] describes the instruction currently in stage k.
- Reset:
  - Asynchronous on rst: all e[k].v=0; stall_cnt=0; flush_cnt=0.
  - Outputs during and after reset: stall=0, freeze=0, fwd_sel1=0, fwd_sel2=0, fwd_data = rf_data.
  - A reset asserted mid-stall or mid-wait clears everything on the same edge.
- Match rule for rs1 (rs2 is identical):
  - A match exists when id_rs1_used=1, id_rs1!=0, and there is at least one k with e[k].v=1 and e[k].rd==id_rs1.
  - Take the smallest such k (the youngest producer). The WB stage is included so that write-then-read in the same cycle is covered.
- Hazard:
  - hz = id_valid & ((a match on rs1 with e[k].ld=1 and k<LOAD_STAGE) or the same condition on rs2).
  - stall = hz & ~flush & ~mem_wait.
- Forwarding (combinational):
  - When a match exists, fwd_sel1=k and fwd_data1=stage_data slice k.
  - Otherwise fwd_sel1=0 and fwd_data1=rf_data1.
  - Forwarded values are don't-care while stall=1.
- freeze = mem_wait (combinational).
- Scoreboard update on the rising edge:
  - mem_wait=1: all entries hold. This takes priority over flush and stall; flush is ignored, so the requester must hold flush until mem_wait drops.
  - Otherwise, e[k+1] <= e[k] for k=1..DEPTH-1, and the entry leaving stage DEPTH is discarded.
  - e[1] <= {0,-,-} (a bubble) if flush or stall.
  - Otherwise e[1] <= {id_valid & id_reg_write & (id_rd!=0), id_rd, id_is_load}.
- Flush and stall in the same cycle: flush wins, because the stalled ID instruction is on the wrong path. stall stays 0 and no stall count is taken.
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where flush=1 and mem_wait=0.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Latency: forwarding and stall are zero-cycle combinational from the inputs and the scoreboard. The scoreboard advances exactly one stage per non-frozen edge.
- A load-use stall lasts LOAD_STAGE-k cycles. With the defaults, a load immediately followed by a consumer stalls for exactly 1 cycle.

Test Plan:
1. ALU forwarding from EX: issue add x5 (rd=5, non-load), then a consumer with rs1=5 on the next cycle, with stage_data[1]=0x0000_1234 and rf_data1=0xDEAD_BEEF -> fwd_sel1=1, fwd_data1=0x0000_1234, stall=0.
2. Load-use: issue lw x7, then a consumer with rs2=7, defaults -> stall=1 for one cycle with e[1] a bubble. Next cycle: fwd_sel2=2, fwd_data2=stage_data[2]=0xCAFE_0001, and stall_cnt=1.
3. Youngest-producer priority: issue addi x3 twice back-to-back, with stage_data[1]=0x11 and stage_data[2]=0x22, then rs1=3 -> fwd_sel1=1, fwd_data1=0x11. Also: rd=0 producers never match, and rs1=0 gives fwd_sel1=0.
4. Flush over stall: load-use condition present together with flush=1 -> stall=0, e[1] is a bubble, flush_cnt +1, stall_cnt unchanged.
5. Memory wait: mem_wait=1 for 3 cycles during a load-use condition -> freeze=1, stall=0, scoreboard unchanged, counters unchanged. After mem_wait drops: stall=1 for one cycle.
6. Reset and saturation:
   - rst pulsed asynchronously between edges mid-stall -> stall=0 and all fwd_sel=0 immediately.
   - With CNT_W=4, 20 consecutive stalls -> stall_cnt=15.
